// File: rtl/tiny_fir_decimator_if.sv
// Stream and tap-load bus for tiny_fir_decimator.
// master = upstream/testbench side, slave = the decimator.
interface tiny_fir_decimator_if #(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned TAP_W  = 16
);

    // Serial tap load
    logic [TAP_W-1:0]  tap_din;
    logic              tap_din_valid;
    logic              taps_loaded;

    // Oversampled input stream
    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic              din_ready;

    // Decimated output stream
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;

    modport master (
        output tap_din, tap_din_valid, din, din_valid, dout_ready,
        input  taps_loaded, din_ready, dout, dout_valid
    );

    modport slave (
        input  tap_din, tap_din_valid, din, din_valid, dout_ready,
        output taps_loaded, din_ready, dout, dout_valid
    );

endinterface

// File: rtl/tiny_fir_decimator.sv
// Single-multiplier serial FIR decimator.
// Loads G_NUM_TAPS taps serially, collects G_DECIMATE samples into a circular
// delay line, then runs one MAC per tap and emits one saturated output.
module tiny_fir_decimator #(
    parameter int unsigned G_DATA_WIDTH = 24,
    parameter int unsigned G_TAP_WIDTH  = 16,
    parameter int unsigned G_NUM_TAPS   = 63,
    parameter int unsigned G_DECIMATE   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    tiny_fir_decimator_if.slave   bus
);

    localparam int unsigned DW     = G_DATA_WIDTH;
    localparam int unsigned TW     = G_TAP_WIDTH;
    localparam int unsigned AW     = $clog2(G_NUM_TAPS);
    localparam int unsigned PH_W   = $clog2(G_DECIMATE);
    localparam int unsigned PROD_W = DW + TW;
    localparam int unsigned ACC_W  = DW + TW + 8;

    localparam logic [AW-1:0]   LAST_IDX = AW'(G_NUM_TAPS - 1);
    localparam logic [PH_W-1:0] LAST_PH  = PH_W'(G_DECIMATE - 1);

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [2:0] {
        S_TAPS,
        S_FILL,
        S_MAC,
        S_DRAIN,
        S_RESULT,
        S_OUT
    } state_t;

    // Register file: taps and circular sample delay line
    logic signed [TW-1:0] taps_q  [G_NUM_TAPS];
    logic signed [DW-1:0] dline_q [G_NUM_TAPS];

    state_t                    state_q,       state_d;
    logic [AW-1:0]             tap_cnt_q,     tap_cnt_d;
    logic [AW-1:0]             wr_ptr_q,      wr_ptr_d;
    logic [AW-1:0]             rd_ptr_q,      rd_ptr_d;
    logic [AW-1:0]             mac_k_q,       mac_k_d;
    logic [PH_W-1:0]           phase_q,       phase_d;
    logic signed [PROD_W-1:0]  prod_q,        prod_d;
    logic signed [ACC_W-1:0]   acc_q,         acc_d;
    logic                      taps_loaded_q, taps_loaded_d;
    logic                      din_ready_q,   din_ready_d;
    logic [DW-1:0]             dout_q,        dout_d;
    logic                      dout_valid_q,  dout_valid_d;

    logic                      clear_c;
    logic                      tap_we_c;
    logic                      dline_we_c;
    logic                      accept_c;
    logic signed [PROD_W-1:0]  prod_c;
    logic signed [ACC_W-1:0]   shifted_c;
    logic [DW-1:0]             sat_c;

    assign clear_c  = reset | ~enable;
    assign accept_c = bus.din_valid & din_ready_q;

    // Datapath helpers: current tap product and saturated, rescaled accumulator
    always_comb begin
        prod_c    = taps_q[mac_k_q] * dline_q[rd_ptr_q];
        shifted_c = acc_q >>> (TW - 1);
        if (shifted_c > SAT_MAX) begin
            sat_c = {1'b0, {(DW-1){1'b1}}};
        end else if (shifted_c < SAT_MIN) begin
            sat_c = {1'b1, {(DW-1){1'b0}}};
        end else begin
            sat_c = shifted_c[DW-1:0];
        end
    end

    // Next-state and next-output logic for the load/fill/MAC/output sequence
    always_comb begin
        state_d       = state_q;
        tap_cnt_d     = tap_cnt_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        mac_k_d       = mac_k_q;
        phase_d       = phase_q;
        prod_d        = prod_q;
        acc_d         = acc_q;
        taps_loaded_d = taps_loaded_q;
        dout_d        = dout_q;
        dout_valid_d  = dout_valid_q;
        tap_we_c      = 1'b0;
        dline_we_c    = 1'b0;

        unique case (state_q)
            S_TAPS: begin
                if (bus.tap_din_valid) begin
                    tap_we_c = 1'b1;
                    if (tap_cnt_q == LAST_IDX) begin
                        taps_loaded_d = 1'b1;
                        state_d       = S_FILL;
                    end else begin
                        tap_cnt_d = tap_cnt_q + AW'(1);
                    end
                end
            end

            S_FILL: begin
                if (accept_c) begin
                    dline_we_c = 1'b1;
                    wr_ptr_d   = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + AW'(1);
                    if (phase_q == LAST_PH) begin
                        // Newest sample is the one written now; MAC walks backwards from it
                        phase_d  = '0;
                        acc_d    = '0;
                        rd_ptr_d = wr_ptr_q;
                        mac_k_d  = '0;
                        state_d  = S_MAC;
                    end else begin
                        phase_d = phase_q + PH_W'(1);
                    end
                end
            end

            S_MAC: begin
                prod_d   = prod_c;
                if (mac_k_q != '0) begin
                    acc_d = acc_q + ACC_W'(prod_q);
                end
                rd_ptr_d = (rd_ptr_q == '0) ? LAST_IDX : rd_ptr_q - AW'(1);
                mac_k_d  = mac_k_q + AW'(1);
                if (mac_k_q == LAST_IDX) begin
                    state_d = S_DRAIN;
                end
            end

            S_DRAIN: begin
                acc_d   = acc_q + ACC_W'(prod_q);
                state_d = S_RESULT;
            end

            S_RESULT: begin
                dout_d       = sat_c;
                dout_valid_d = 1'b1;
                state_d      = S_OUT;
            end

            S_OUT: begin
                if (bus.dout_ready) begin
                    dout_valid_d = 1'b0;
                    state_d      = S_FILL;
                end
            end

            default: begin
                state_d = S_TAPS;
            end
        endcase

        if (clear_c) begin
            state_d       = S_TAPS;
            tap_cnt_d     = '0;
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            mac_k_d       = '0;
            phase_d       = '0;
            prod_d        = '0;
            acc_d         = '0;
            taps_loaded_d = 1'b0;
            dout_d        = '0;
            dout_valid_d  = 1'b0;
            tap_we_c      = 1'b0;
            dline_we_c    = 1'b0;
        end

        din_ready_d = (state_d == S_FILL);
    end

    // State and control/output registers
    always_ff @(posedge clk) begin
        state_q       <= state_d;
        tap_cnt_q     <= tap_cnt_d;
        wr_ptr_q      <= wr_ptr_d;
        rd_ptr_q      <= rd_ptr_d;
        mac_k_q       <= mac_k_d;
        phase_q       <= phase_d;
        prod_q        <= prod_d;
        acc_q         <= acc_d;
        taps_loaded_q <= taps_loaded_d;
        din_ready_q   <= din_ready_d;
        dout_q        <= dout_d;
        dout_valid_q  <= dout_valid_d;
    end

    // Tap storage, written only during the serial load
    always_ff @(posedge clk) begin
        if (tap_we_c) begin
            taps_q[tap_cnt_q] <= bus.tap_din;
        end
    end

    // Delay line; cleared on reset so the first outputs see zero history
    always_ff @(posedge clk) begin
        if (clear_c) begin
            for (int unsigned i = 0; i < G_NUM_TAPS; i++) begin
                dline_q[i] <= '0;
            end
        end else if (dline_we_c) begin
            dline_q[wr_ptr_q] <= bus.din;
        end
    end

    assign bus.taps_loaded = taps_loaded_q;
    assign bus.din_ready   = din_ready_q;
    assign bus.dout        = dout_q;
    assign bus.dout_valid  = dout_valid_q;

endmodule

// File: tb/tb_tiny_fir_decimator.sv
// Self-checking bench for tiny_fir_decimator against a sum-of-products model.
module tb_tiny_fir_decimator;

    localparam int unsigned DW = 24;
    localparam int unsigned TW = 16;
    localparam int unsigned N  = 63;
    localparam int unsigned D  = 2;

    localparam longint DMAX = (longint'(1) <<< (DW - 1)) - 1;
    localparam longint DMIN = -(longint'(1) <<< (DW - 1));

    logic clk = 1'b0;
    logic reset;
    logic enable;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tiny_fir_decimator_if #(.DATA_W(DW), .TAP_W(TW)) bus ();

    tiny_fir_decimator #(
        .G_DATA_WIDTH (DW),
        .G_TAP_WIDTH  (TW),
        .G_NUM_TAPS   (N),
        .G_DECIMATE   (D)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .bus    (bus)
    );

    int     checks = 0;
    int     errors = 0;

    longint tap_set [N];
    longint taps_m  [N];
    longint hist    [$];
    longint src_q   [$];
    longint exp_q   [$];
    longint got_q   [$];

    task automatic check(input string tag, input logic signed [63:0] obs, input longint expv);
        checks++;
        assert (obs === 64'(expv)) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: y = sat( floor( sum_k tap[k]*x[n-k] / 2^(TW-1) ) ), x before reset = 0
    function automatic longint model_out();
        longint sum = 0;
        longint r;
        for (int k = 0; k < int'(N); k++) begin
            int idx = hist.size() - 1 - k;
            if (idx >= 0) sum += taps_m[k] * hist[idx];
        end
        r = sum >>> (TW - 1);
        if (r > DMAX) r = DMAX;
        if (r < DMIN) r = DMIN;
        return r;
    endfunction

    // One-cycle reset or enable drop, with a stray tap pulse that must be ignored
    task automatic apply_clear(input bit use_enable);
        if (use_enable) enable = 1'b0;
        else            reset  = 1'b1;
        bus.tap_din       = 16'h7abc;
        bus.tap_din_valid = 1'b1;
        bus.din_valid     = 1'b0;
        bus.dout_ready    = 1'b0;
        step();
        reset             = 1'b0;
        enable            = 1'b1;
        bus.tap_din_valid = 1'b0;
        check("clr_taps_loaded", 64'(bus.taps_loaded), 0);
        check("clr_din_ready",   64'(bus.din_ready),   0);
        check("clr_dout_valid",  64'(bus.dout_valid),  0);
        check("clr_dout",        64'(bus.dout),        0);
        hist.delete();
        exp_q.delete();
    endtask

    // Serial tap load from tap_set, optionally with idle gaps
    task automatic load_taps(input bit gaps);
        for (int k = 0; k < int'(N); k++) begin
            if (gaps && (k % 10 == 5) && (k < 55)) begin
                bus.tap_din_valid = 1'b0;
                bus.tap_din       = 16'($urandom);
                step();
                check("gap_taps_loaded", 64'(bus.taps_loaded), 0);
                check("gap_din_ready",   64'(bus.din_ready),   0);
            end
            bus.tap_din       = TW'(tap_set[k]);
            bus.tap_din_valid = 1'b1;
            if (bus.taps_loaded !== 1'b0 || bus.din_ready !== 1'b0) begin
                check("load_early_taps_loaded", 64'(bus.taps_loaded), 0);
                check("load_early_din_ready",   64'(bus.din_ready),   0);
            end
            step();
        end
        bus.tap_din_valid = 1'b0;
        check("taps_loaded_rise", 64'(bus.taps_loaded), 1);
        check("din_ready_after_load", 64'(bus.din_ready), 1);
        for (int k = 0; k < int'(N); k++) taps_m[k] = tap_set[k];
    endtask

    // Feed src_q, scoreboard every output; mode 1 = random gaps, bp = one 10-cycle stall
    task automatic stream(input bit rnd, input bit bp);
        int     budget    = 400 + (src_q.size() / int'(D) + 2) * int'(N + D + 3) * 3;
        int     last_edge = 0;
        int     hold      = 0;
        bit     bp_done   = 1'b0;
        bit     prev_vld  = 1'b0;
        logic [DW-1:0] held = '0;
        while ((src_q.size() > 0 || exp_q.size() > 0) && budget > 0) begin
            bus.din_valid = (src_q.size() > 0) && (!rnd || ($urandom_range(0, 1) == 1));
            bus.din       = bus.din_valid ? DW'(src_q[0]) : DW'($urandom);
            if (bp && !bp_done && bus.dout_valid) begin
                bp_done = 1'b1;
                hold    = 10;
                held    = bus.dout;
            end
            if (hold > 0) begin
                bus.dout_ready = 1'b0;
                check("bp_dout_stable", 64'(bus.dout),       longint'(held));
                check("bp_din_ready",   64'(bus.din_ready),  0);
                check("bp_dout_valid",  64'(bus.dout_valid), 1);
                hold--;
            end else begin
                bus.dout_ready = !rnd || ($urandom_range(0, 3) != 0);
            end
            if (bus.dout_valid && !prev_vld) begin
                check("latency", 64'(cyc - last_edge), longint'(N + 2));
            end
            if (bus.din_valid && bus.din_ready) begin
                hist.push_back(src_q.pop_front());
                if (hist.size() % int'(D) == 0) begin
                    exp_q.push_back(model_out());
                    last_edge = cyc + 1;
                end
            end
            if (bus.dout_valid && bus.dout_ready) begin
                if (exp_q.size() == 0) begin
                    check("dout_spurious", 64'(bus.dout_valid), 0);
                end else begin
                    check("dout", 64'($signed(bus.dout)), exp_q.pop_front());
                    got_q.push_back(longint'($signed(bus.dout)));
                end
            end
            prev_vld = bus.dout_valid;
            step();
            budget--;
        end
        if (budget == 0) check("stream_timeout", 64'(src_q.size() + exp_q.size()), 0);
        bus.din_valid  = 1'b0;
        bus.dout_ready = 1'b0;
    endtask

    task automatic impulse_run();
        got_q.delete();
        src_q.push_back(32768);
        for (int i = 0; i < 65; i++) src_q.push_back(0);
        stream(1'b0, 1'b0);
        check("impulse_count", 64'(got_q.size()), 33);
        for (int i = 0; i < got_q.size(); i++) begin
            check("impulse_seq", 64'(got_q[i]), (i < 31) ? longint'(2 * (i + 1)) : 0);
        end
    endtask

    initial begin
        reset             = 1'b1;
        enable            = 1'b1;
        bus.tap_din       = '0;
        bus.tap_din_valid = 1'b0;
        bus.din           = '0;
        bus.din_valid     = 1'b0;
        bus.dout_ready    = 1'b0;
        step();
        step();
        reset = 1'b0;
        check("rst_taps_loaded", 64'(bus.taps_loaded), 0);
        check("rst_din_ready",   64'(bus.din_ready),   0);
        check("rst_dout_valid",  64'(bus.dout_valid),  0);
        check("rst_dout",        64'(bus.dout),        0);

        // Impulse response with ramp taps; extra tap after load must be ignored
        for (int k = 0; k < int'(N); k++) tap_set[k] = k + 1;
        load_taps(1'b1);
        bus.tap_din       = 16'h1234;
        bus.tap_din_valid = 1'b1;
        step();
        bus.tap_din_valid = 1'b0;
        check("extra_tap_taps_loaded", 64'(bus.taps_loaded), 1);
        impulse_run();

        // Reset while the MAC is at k=20, then reload and replay
        apply_clear(1'b0);
        load_taps(1'b0);
        bus.din_valid = 1'b1;
        bus.din       = DW'(32768);
        step();
        bus.din       = '0;
        step();
        bus.din_valid = 1'b0;
        for (int i = 0; i < 20; i++) step();
        check("mac_din_ready", 64'(bus.din_ready), 0);
        apply_clear(1'b0);
        load_taps(1'b0);
        impulse_run();

        // Saturation at both rails
        apply_clear(1'b0);
        for (int k = 0; k < int'(N); k++) tap_set[k] = 32767;
        load_taps(1'b0);
        got_q.delete();
        for (int i = 0; i < 64; i++) src_q.push_back(DMAX);
        stream(1'b0, 1'b0);
        check("sat_pos", got_q[got_q.size() - 1], DMAX);
        got_q.delete();
        for (int i = 0; i < 64; i++) src_q.push_back(DMIN);
        stream(1'b0, 1'b0);
        check("sat_neg", got_q[got_q.size() - 1], DMIN);

        // Random taps and data with gaps, random ready and one long stall
        apply_clear(1'b0);
        for (int k = 0; k < int'(N); k++) tap_set[k] = longint'($signed(TW'($urandom)));
        load_taps(1'b1);
        for (int i = 0; i < 40; i++) src_q.push_back(longint'($signed(DW'($urandom))));
        stream(1'b1, 1'b1);

        // enable=0 mid-fill clears the delay line; new data must see no old history
        bus.din_valid = 1'b1;
        bus.din       = DW'(24'h3fffff);
        step();
        bus.din_valid = 1'b0;
        check("fill_din_ready", 64'(bus.din_ready), 1);
        apply_clear(1'b1);
        for (int k = 0; k < int'(N); k++) tap_set[k] = longint'($signed(TW'($urandom)));
        load_taps(1'b0);
        for (int i = 0; i < 20; i++) src_q.push_back(longint'($signed(DW'($urandom))));
        stream(1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
